// File: rtl/receiver_if.sv
// Serial-receive bundle: the incoming line plus the recovered byte and its strobes.
interface receiver_if;
   logic       rx_line;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;

   // Receiver side: consumes the line and produces byte/strobes.
   modport master (
      input  rx_line,
      output data_out,
      output rx_valid,
      output rx_busy,
      output frame_err
   );

   // Consumer side: drives the line and observes the results.
   modport slave (
      output rx_line,
      input  data_out,
      input  rx_valid,
      input  rx_busy,
      input  frame_err
   );
endinterface

// File: rtl/receiver.sv
// 8N1 UART receiver with mid-bit sampling. The start bit is confirmed half a
// bit after the falling edge, so every later sample lands at a bit centre.
// A frame whose stop bit reads low raises frame_err instead of rx_valid and
// leaves the last good byte on data_out.
module receiver #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic      clk,
   input  logic      reset,
   receiver_if.master bus
);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_CLEANUP
   } state_t;

   logic          s1_q;
   logic          rx_s_q;
   state_t        state_q,   state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q,   shift_d;
   logic [7:0]    data_q,    data_d;
   logic          valid_q,   valid_d;
   logic          ferr_q,    ferr_d;

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= 1'b1;
         rx_s_q <= 1'b1;
      end else begin
         s1_q   <= bus.rx_line;
         rx_s_q <= s1_q;
      end
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   // Next-state logic: count to the sample point, sample, then restart the count.
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q + CW'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            if (clk_cnt_q == HALF_M1) begin
               clk_cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  // Line went back high before mid-start: treat as a glitch.
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d          = '0;
               shift_d[bit_idx_q] = rx_s_q;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         S_STOP: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d = '0;
               state_d   = S_CLEANUP;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         S_CLEANUP: begin
            // Wait for the line to be high so a break is not read as a new start.
            clk_cnt_d = '0;
            if (rx_s_q) state_d = S_IDLE;
         end
         default: begin
            clk_cnt_d = '0;
            state_d   = S_IDLE;
         end
      endcase
   end

   assign bus.data_out  = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.rx_busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_receiver.sv
// Bench for the UART receiver: an ideal serial driver plus a frame-level
// reference model predicting, per frame, the cycle and kind of the result strobe.
module tb_receiver;
   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   // Driver changes the line in cycle c; s1 captures at c+1 (=E); stop sample at E+154.
   localparam int LAT  = 1 + 2 + HALF + 9 * CPB;

   typedef struct {
      int         cyc;
      bit         err;
      logic [7:0] d;
   } ev_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   ev_t exp_q[$];
   ev_t obs_q[$];
   logic [7:0] last_good;

   int n_valid, n_err, n_busy, busy_rises;
   int n_both   = 0;
   int unstable = 0;

   receiver_if bus ();

   receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Observe outputs at the falling edge, away from the active edge.
   initial begin
      logic       first = 1'b1;
      logic [7:0] prev_d = 8'h00;
      logic       prev_rst = 1'b1;
      logic       prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.rx_valid && bus.frame_err) n_both++;
         if (bus.rx_valid) begin
            n_valid++;
            obs_q.push_back('{cyc: cyc, err: 1'b0, d: bus.data_out});
         end
         if (bus.frame_err) begin
            n_err++;
            obs_q.push_back('{cyc: cyc, err: 1'b1, d: bus.data_out});
         end
         if (bus.rx_busy) n_busy++;
         if (bus.rx_busy && !prev_busy) busy_rises++;
         if (!first && bus.data_out !== prev_d && !bus.rx_valid && !prev_rst) unstable++;
         first     = 1'b0;
         prev_d    = bus.data_out;
         prev_rst  = reset;
         prev_busy = bus.rx_busy;
      end
   end

   task automatic clear_mon();
      n_valid    = 0;
      n_err      = 0;
      n_busy     = 0;
      busy_rises = 0;
      obs_q.delete();
      exp_q.delete();
   endtask

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                             input int low_after, input int gap);
      int c;
      c = cyc;
      if (stop_ok) begin
         exp_q.push_back('{cyc: c + LAT, err: 1'b0, d: b});
         last_good = b;
      end else begin
         exp_q.push_back('{cyc: c + LAT, err: 1'b1, d: last_good});
      end
      bus.rx_line = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         bus.rx_line = b[i];
         wait_cyc(CPB);
      end
      bus.rx_line = stop_ok;
      wait_cyc(CPB);
      if (!stop_ok && low_after > 0) begin
         wait_cyc(low_after);
         check_eq("busy_held_low", bus.rx_busy, 1);
      end
      bus.rx_line = 1'b1;
      wait_cyc(gap);
   endtask

   task automatic compare_events(input string tag);
      check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         check_eq($sformatf("%s_cyc%0d", tag, i), obs_q[i].cyc, exp_q[i].cyc);
         check_eq($sformatf("%s_kind%0d", tag, i), obs_q[i].err, exp_q[i].err);
         check_eq($sformatf("%s_data%0d", tag, i), obs_q[i].d, exp_q[i].d);
      end
   endtask

   initial begin
      logic [7:0] b2b [4];
      b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'h80;
      last_good   = 8'h00;
      reset       = 1'b1;
      bus.rx_line = 1'b1;
      clear_mon();

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_data", bus.data_out, 8'h00);
      check_eq("rst_valid", bus.rx_valid, 0);
      check_eq("rst_busy", bus.rx_busy, 0);
      check_eq("rst_ferr", bus.frame_err, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      wait_cyc(5);

      // Single frame 0xA5
      clear_mon();
      send_frame(8'hA5, 1'b1, 0, 20);
      compare_events("single");
      check_eq("single_nerr", n_err, 0);
      check_eq("single_data", bus.data_out, 8'hA5);

      // Back-to-back frames with no idle gap
      clear_mon();
      for (int i = 0; i < 4; i++) send_frame(b2b[i], 1'b1, 0, (i == 3) ? 20 : 0);
      compare_events("b2b");
      check_eq("b2b_nvalid", n_valid, 4);
      check_eq("b2b_busy_rises", busy_rises, 4);

      // 4-cycle low glitch on idle line
      clear_mon();
      bus.rx_line = 1'b0;
      wait_cyc(4);
      bus.rx_line = 1'b1;
      wait_cyc(30);
      check_eq("glitch_busy_len", (n_busy >= HALF && n_busy <= HALF + 1), 1);
      check_eq("glitch_busy_rises", busy_rises, 1);
      check_eq("glitch_valid", n_valid, 0);
      check_eq("glitch_ferr", n_err, 0);
      check_eq("glitch_idle", bus.rx_busy, 0);

      // Good 0x11 then 0x3C with a bad stop bit and a held-low line
      clear_mon();
      send_frame(8'h11, 1'b1, 0, 5);
      send_frame(8'h3C, 1'b0, 40, 10);
      compare_events("ferr");
      check_eq("ferr_nvalid", n_valid, 1);
      check_eq("ferr_nerr", n_err, 1);
      check_eq("ferr_data_kept", bus.data_out, 8'h11);
      check_eq("ferr_idle_after", bus.rx_busy, 0);

      // Reset pulse during data bit 4 of a frame
      clear_mon();
      bus.rx_line = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 4; i++) begin
         bus.rx_line = 1'b1;
         wait_cyc(CPB);
      end
      bus.rx_line = 1'b0;
      wait_cyc(HALF);
      check_eq("midrst_busy_before", bus.rx_busy, 1);
      reset       = 1'b1;
      bus.rx_line = 1'b1;
      wait_cyc(1);
      reset = 1'b0;
      @(negedge clk);
      check_eq("midrst_busy", bus.rx_busy, 0);
      check_eq("midrst_data", bus.data_out, 8'h00);
      check_eq("midrst_valid", bus.rx_valid, 0);
      check_eq("midrst_ferr", bus.frame_err, 0);
      @(posedge clk); #1;
      last_good = 8'h00;
      wait_cyc(30);
      send_frame(8'hC3, 1'b1, 0, 20);
      compare_events("midrst");
      check_eq("midrst_final", bus.data_out, 8'hC3);

      // Randomized frames: random bytes, occasional bad stop bits, random gaps
      clear_mon();
      for (int i = 0; i < 10; i++) begin
         logic [7:0] b;
         bit ok;
         b  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 3) != 0);
         if (ok) send_frame(b, 1'b1, 0, $urandom_range(0, 12));
         else    send_frame(b, 1'b0, $urandom_range(0, 30), $urandom_range(2, 12));
      end
      wait_cyc(20);
      compare_events("rand");

      check_eq("never_both", n_both, 0);
      check_eq("data_stable", unstable, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
